// File: rtl/ber_pkg.sv
// rtl/ber_pkg.sv - shared state encoding, PRBS9 step function and clog2 helper for ber_monitor
package ber_pkg;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_TRIAL  = 2'd1,
        ST_LOCKED = 2'd2
    } ch_state_t;

    localparam int PRBS_TAP_A = 9;
    localparam int PRBS_TAP_B = 5;
    localparam int PRBS_LEN   = PRBS_TAP_A;
    localparam logic [PRBS_LEN-1:0] PRBS_TAP_MASK =
        PRBS_LEN'((1 << (PRBS_TAP_A - 1)) | (1 << (PRBS_TAP_B - 1)));

    // Returns {predicted bit, next LFSR state}; in sync mode the received bit is loaded instead of the prediction.
    function automatic logic [PRBS_LEN:0] prbs9_step(input logic [PRBS_LEN-1:0] s,
                                                     input logic rx,
                                                     input logic load_rx);
        logic p;
        p = ^(s & PRBS_TAP_MASK);
        return {p, s[PRBS_LEN-2:0], (load_rx ? rx : p)};
    endfunction

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prbs_checker_ch.sv
// rtl/prbs_checker_ch.sv - one channel of PRBS9 self-sync, lock qualification and saturating BER counters
module prbs_checker_ch
    import ber_pkg::*;
#(
    parameter int NB_CNT  = 64,
    parameter int WINDOW  = 128,
    parameter int MAX_ERR = 4
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              rx_bit,
    input  logic              bit_vld,
    input  logic              i_clear,
    output logic              locked,
    output logic [NB_CNT-1:0] bit_count,
    output logic [NB_CNT-1:0] err_count
);

    localparam int WW = clog2_min1(WINDOW + 2);
    localparam logic [WW-1:0] WIN_END  = WW'(WINDOW);
    localparam logic [WW-1:0] ERR_OK   = WW'(MAX_ERR);
    localparam logic [WW-1:0] ERR_DROP = WW'(MAX_ERR + 1);
    localparam logic [WW-1:0] SYNC_END = WW'(PRBS_LEN);

    ch_state_t             state;
    logic [PRBS_LEN-1:0]   lfsr;
    logic [WW-1:0]         win_bits;
    logic [WW-1:0]         win_err;
    logic [PRBS_LEN:0]     step;
    logic                  err_bit;
    logic [WW-1:0]         bits_nx;
    logic [WW-1:0]         err_nx;

    assign step    = prbs9_step(lfsr, rx_bit, state == ST_SYNC);
    assign err_bit = rx_bit ^ step[PRBS_LEN];
    assign bits_nx = win_bits + WW'(1);
    assign err_nx  = win_err + WW'(err_bit);

    // win_bits/win_err are reused as sync counter, trial window and lock-monitor block.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_SYNC;
            lfsr      <= '0;
            win_bits  <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            bit_count <= '0;
            err_count <= '0;
        end else begin
            if (bit_vld) begin
                lfsr <= step[PRBS_LEN-1:0];
                case (state)
                    ST_SYNC: begin
                        win_err <= '0;
                        if (bits_nx == SYNC_END) begin
                            state    <= ST_TRIAL;
                            win_bits <= '0;
                        end else begin
                            win_bits <= bits_nx;
                        end
                    end
                    ST_TRIAL: begin
                        if (bits_nx == WIN_END) begin
                            win_bits <= '0;
                            win_err  <= '0;
                            if (err_nx <= ERR_OK) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= ST_SYNC;
                            end
                        end else begin
                            win_bits <= bits_nx;
                            win_err  <= err_nx;
                        end
                    end
                    ST_LOCKED: begin
                        if (!(&bit_count)) bit_count <= bit_count + NB_CNT'(1);
                        if (err_bit && !(&err_count)) err_count <= err_count + NB_CNT'(1);
                        if (err_nx == ERR_DROP) begin
                            state    <= ST_SYNC;
                            locked   <= 1'b0;
                            win_bits <= '0;
                            win_err  <= '0;
                        end else if (bits_nx == WIN_END) begin
                            win_bits <= '0;
                            win_err  <= '0;
                        end else begin
                            win_bits <= bits_nx;
                            win_err  <= err_nx;
                        end
                    end
                    default: begin
                        state    <= ST_SYNC;
                        locked   <= 1'b0;
                        win_bits <= '0;
                        win_err  <= '0;
                    end
                endcase
            end
            if (i_clear) begin
                bit_count <= '0;
                err_count <= '0;
            end
        end
    end

endmodule

// File: rtl/ber_monitor.sv
// rtl/ber_monitor.sv - multi-channel PRBS9 BER monitor: phase select, sign slicer, per-channel checkers, count mux
module ber_monitor
    import ber_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int OS      = 4,
    parameter int NCH     = 2,
    parameter int NB_CNT  = 64,
    parameter int WINDOW  = 128,
    parameter int MAX_ERR = 4
) (
    input  logic                      clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [clog2_min1(OS)-1:0] i_phase,
    input  logic [NCH*NB_DATA-1:0]    i_data,
    input  logic                      i_clear,
    input  logic [clog2_min1(NCH)-1:0] i_ch_sel,
    output logic [NCH-1:0]            o_locked,
    output logic [NB_CNT-1:0]         o_bit_count,
    output logic [NB_CNT-1:0]         o_err_count,
    output logic                      o_ber_zero
);

    localparam int PW = clog2_min1(OS);
    localparam logic signed [NB_DATA-1:0] ZERO_S = '0;

    logic [PW-1:0]     pc;
    logic              strobe;
    logic              bit_vld;
    logic [NCH-1:0]    rx_bit;
    logic [NB_CNT-1:0] bit_cnt [NCH];
    logic [NB_CNT-1:0] err_cnt [NCH];
    logic [NCH-1:0]    err_zero;

    assign strobe = i_enable && (pc == i_phase);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            pc      <= '0;
            bit_vld <= 1'b0;
            rx_bit  <= '0;
        end else begin
            bit_vld <= strobe;
            if (i_enable) pc <= (pc == PW'(OS - 1)) ? '0 : pc + PW'(1);
            // Negative sample slices to 1, matching the 1 -> -1 BPSK mapping.
            if (strobe) begin
                for (int k = 0; k < NCH; k++) begin
                    rx_bit[k] <= ($signed(i_data[k*NB_DATA +: NB_DATA]) < ZERO_S);
                end
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        prbs_checker_ch #(
            .NB_CNT  (NB_CNT),
            .WINDOW  (WINDOW),
            .MAX_ERR (MAX_ERR)
        ) u_chk (
            .clock     (clock),
            .i_reset   (i_reset),
            .rx_bit    (rx_bit[k]),
            .bit_vld   (bit_vld),
            .i_clear   (i_clear),
            .locked    (o_locked[k]),
            .bit_count (bit_cnt[k]),
            .err_count (err_cnt[k])
        );
        assign err_zero[k] = (err_cnt[k] == '0);
    end

    always_comb begin
        o_bit_count = bit_cnt[0];
        o_err_count = err_cnt[0];
        for (int k = 1; k < NCH; k++) begin
            if (int'(i_ch_sel) == k) begin
                o_bit_count = bit_cnt[k];
                o_err_count = err_cnt[k];
            end
        end
    end

    assign o_ber_zero = (&o_locked) && (&err_zero);

endmodule

// File: tb/tb_ber_monitor.sv
// tb/tb_ber_monitor.sv - directed PRBS9 BPSK stimulus with bit-level reference model for ber_monitor
module tb_ber_monitor;

    localparam int NCH     = 2;
    localparam int NB_DATA = 8;
    localparam int OS      = 4;
    localparam int WINDOW  = 128;
    localparam int MAX_ERR = 4;
    localparam int M_SYNC = 0, M_TRIAL = 1, M_LOCKED = 2;

    logic        clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [1:0]  i_phase;
    logic [15:0] i_data;
    logic        i_clear;
    logic [0:0]  i_ch_sel;

    logic [1:0]  locked_a, locked_b;
    logic [63:0] bc_a, ec_a;
    logic [7:0]  bc_b, ec_b;
    logic        bz_a, bz_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    ber_monitor dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_phase(i_phase),
        .i_data(i_data), .i_clear(i_clear), .i_ch_sel(i_ch_sel), .o_locked(locked_a),
        .o_bit_count(bc_a), .o_err_count(ec_a), .o_ber_zero(bz_a)
    );

    ber_monitor #(.NB_CNT(8)) dut8 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_phase(i_phase),
        .i_data(i_data), .i_clear(i_clear), .i_ch_sel(i_ch_sel), .o_locked(locked_b),
        .o_bit_count(bc_b), .o_err_count(ec_b), .o_ber_zero(bz_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works bit by bit on a 9-deep history queue (oldest first).
    int          m_state [NCH];
    int          m_nbits [NCH];
    int          m_nerr  [NCH];
    bit          m_hist  [NCH][$];
    logic [63:0] m_bc    [NCH];
    logic [63:0] m_ec    [NCH];
    logic [7:0]  m_bc8   [NCH];
    logic [7:0]  m_ec8   [NCH];
    bit          m_vld;
    bit          m_rx    [NCH];
    int          m_pc;

    task automatic hist_push(input int k, input bit b);
        m_hist[k].push_back(b);
        void'(m_hist[k].pop_front());
    endtask

    task automatic model_bit(input int k, input bit b);
        bit pred, e;
        pred = m_hist[k][0] ^ m_hist[k][4];
        e    = b ^ pred;
        if (m_state[k] == M_SYNC) begin
            hist_push(k, b);
            m_nbits[k]++;
            if (m_nbits[k] == 9) begin
                m_state[k] = M_TRIAL;
                m_nbits[k] = 0;
                m_nerr[k]  = 0;
            end
        end else if (m_state[k] == M_TRIAL) begin
            hist_push(k, pred);
            m_nbits[k]++;
            m_nerr[k] += int'(e);
            if (m_nbits[k] == WINDOW) begin
                m_state[k] = (m_nerr[k] <= MAX_ERR) ? M_LOCKED : M_SYNC;
                m_nbits[k] = 0;
                m_nerr[k]  = 0;
            end
        end else begin
            hist_push(k, pred);
            if (m_bc[k] != '1) m_bc[k] = m_bc[k] + 1;
            if (m_bc8[k] != '1) m_bc8[k] = m_bc8[k] + 1;
            if (e && m_ec[k] != '1) m_ec[k] = m_ec[k] + 1;
            if (e && m_ec8[k] != '1) m_ec8[k] = m_ec8[k] + 1;
            m_nbits[k]++;
            m_nerr[k] += int'(e);
            if (m_nerr[k] == MAX_ERR + 1) begin
                m_state[k] = M_SYNC;
                m_nbits[k] = 0;
                m_nerr[k]  = 0;
            end else if (m_nbits[k] == WINDOW) begin
                m_nbits[k] = 0;
                m_nerr[k]  = 0;
            end
        end
    endtask

    always @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < NCH; k++) begin
                m_state[k] = M_SYNC;
                m_nbits[k] = 0;
                m_nerr[k]  = 0;
                m_bc[k] = '0; m_ec[k] = '0; m_bc8[k] = '0; m_ec8[k] = '0;
                m_rx[k] = 1'b0;
                m_hist[k] = {};
                for (int j = 0; j < 9; j++) m_hist[k].push_back(1'b0);
            end
            m_vld = 1'b0;
            m_pc  = 0;
        end else begin
            if (m_vld) for (int k = 0; k < NCH; k++) model_bit(k, m_rx[k]);
            if (i_clear) begin
                for (int k = 0; k < NCH; k++) begin
                    m_bc[k] = '0; m_ec[k] = '0; m_bc8[k] = '0; m_ec8[k] = '0;
                end
            end
            m_vld = i_enable && (m_pc == int'(i_phase));
            if (m_vld) for (int k = 0; k < NCH; k++) m_rx[k] = i_data[k*NB_DATA + NB_DATA - 1];
            if (i_enable) m_pc = (m_pc + 1) % OS;
        end
    end

    always @(negedge clock) begin
        int sel;
        logic [NCH-1:0] el;
        logic ez, ez8;
        sel = (int'(i_ch_sel) < NCH) ? int'(i_ch_sel) : 0;
        ez = 1'b1;
        ez8 = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            el[k] = (m_state[k] == M_LOCKED);
            ez    = ez && (m_ec[k] == 0);
            ez8   = ez8 && (m_ec8[k] == 0);
        end
        chk("cyc_locked",     64'(locked_a), 64'(el));
        chk("cyc_bit_count",  bc_a,          m_bc[sel]);
        chk("cyc_err_count",  ec_a,          m_ec[sel]);
        chk("cyc_ber_zero",   64'(bz_a),     64'((&el) && ez));
        chk("cyc8_locked",    64'(locked_b), 64'(el));
        chk("cyc8_bit_count", 64'(bc_b),     64'(m_bc8[sel]));
        chk("cyc8_err_count", 64'(ec_b),     64'(m_ec8[sel]));
        chk("cyc8_ber_zero",  64'(bz_b),     64'((&el) && ez8));
    end

    // PRBS9 source: first nine bits are the seed, then b[n] = b[n-9] ^ b[n-5].
    logic [8:0] seed = 9'h1AA;
    int         gen_n = 0;
    bit         gen_q[$];

    task automatic gen_next(output bit b);
        if (gen_n < 9) b = seed[8 - gen_n];
        else           b = gen_q[0] ^ gen_q[4];
        gen_q.push_back(b);
        if (gen_q.size() > 9) void'(gen_q.pop_front());
        gen_n++;
    endtask

    function automatic logic [7:0] sym(input bit b);
        return b ? 8'hC0 : 8'h40;
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic send_sym(input bit b0, input bit b1, input bit clr);
        i_data = {sym(b1), sym(b0)};
        for (int t = 0; t < OS; t++) begin
            tick();
            if (clr && t == OS - 2) i_clear = 1'b1;
            if (t == OS - 1) i_clear = 1'b0;
        end
    endtask

    initial begin
        bit b, r, f;
        i_reset = 1'b0; i_enable = 1'b0; i_clear = 1'b0;
        i_phase = 2'd2; i_ch_sel = 1'b0; i_data = '0;

        repeat (5) begin
            i_data   = 16'($urandom);
            i_enable = 1'($urandom);
            tick();
        end
        chk("rst_locked", 64'(locked_a), 64'd0);
        chk("rst_bits",   bc_a,          64'd0);
        chk("rst_errs",   ec_a,          64'd0);
        chk("rst_bz",     64'(bz_a),     64'd0);
        i_reset = 1'b1; i_enable = 1'b0; i_data = '0;
        repeat (3) tick();
        chk("post_rst_locked", 64'(locked_a), 64'd0);
        chk("post_rst_bits",   bc_a,          64'd0);

        i_enable = 1'b1;
        for (int i = 0; i < 136; i++) begin gen_next(b); send_sym(b, b, 1'b0); end
        chk("prelock_136", 64'(locked_a), 64'd0);
        gen_next(b); send_sym(b, b, 1'b0);
        chk("lock_137", 64'(locked_a), 64'd3);

        for (int i = 0; i < 1000; i++) begin gen_next(b); send_sym(b, b, 1'b0); end
        chk("clean_bits", bc_a,      64'd1000);
        chk("clean_errs", ec_a,      64'd0);
        chk("clean_bz",   64'(bz_a), 64'd1);
        chk("sat8_bits",  64'(bc_b), 64'd255);

        for (int i = 0; i < 600; i++) begin
            gen_next(b);
            f = (i % 200 == 100);
            send_sym(b ^ f, b, 1'b0);
        end
        chk("sparse_errs",   ec_a,          64'd3);
        chk("sparse_locked", 64'(locked_a), 64'd3);
        chk("sparse_bz",     64'(bz_a),     64'd0);
        chk("sparse_bits",   bc_a,          64'd1600);
        chk("sat8_hold",     64'(bc_b),     64'd255);

        for (int i = 0; i < 19; i++) begin
            gen_next(b);
            f = (i >= 10) && (i % 2 == 0);
            send_sym(b ^ f, b, 1'b0);
        end
        chk("burst_locked", 64'(locked_a), 64'd2);
        chk("burst_errs",   ec_a,          64'd8);
        chk("burst_bits",   bc_a,          64'd1619);
        for (int i = 0; i < 137; i++) begin gen_next(b); send_sym(b, b, 1'b0); end
        chk("relock_locked", 64'(locked_a), 64'd3);
        chk("relock_bits",   bc_a,          64'd1619);
        chk("relock_errs",   ec_a,          64'd8);
        for (int i = 0; i < 100; i++) begin gen_next(b); send_sym(b, b, 1'b0); end
        chk("resume_bits", bc_a, 64'd1719);

        i_reset = 1'b0; i_enable = 1'b0;
        repeat (2) tick();
        i_reset = 1'b1;
        repeat (2) tick();
        i_enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            gen_next(b);
            r = 1'($urandom);
            send_sym(b, r, 1'b0);
        end
        chk("indep_locked", 64'(locked_a), 64'd1);
        i_ch_sel = 1'b1;
        #1;
        chk("indep_ch1_bits", bc_a,      64'd0);
        chk("indep_bz",       64'(bz_a), 64'd0);
        i_ch_sel = 1'b0;
        #1;
        chk("indep_ch0_bits", bc_a,      64'd163);
        chk("indep8_ch0",     64'(bc_b), 64'd163);

        i_enable = 1'b0;
        repeat (12) tick();
        chk("pause_locked", 64'(locked_a), 64'd1);
        chk("pause_bits",   bc_a,          64'd163);
        i_enable = 1'b1;

        gen_next(b); r = 1'($urandom);
        send_sym(b, r, 1'b1);
        chk("clear_bits",   bc_a,          64'd0);
        chk("clear_errs",   ec_a,          64'd0);
        chk("clear8_bits",  64'(bc_b),     64'd0);
        chk("clear_locked", 64'(locked_a), 64'd1);
        for (int i = 0; i < 20; i++) begin gen_next(b); r = 1'($urandom); send_sym(b, r, 1'b0); end
        chk("post_clear_bits", bc_a, 64'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ber_monitor.md
Name: ber_monitor

Overview:
- Multi-channel receive-side BER monitor for the PRBS9 + BPSK + RC link; sits after the RC filter output(s) in the system top.
- Per channel:
  - picks one of OS sample phases and slices the sign bit;
  - self-synchronises a local PRBS9 checker to the received stream;
  - qualifies lock over a trial window;
  - counts bits and errors while locked.
- Generalises the single-channel, fixed-offset scheme to NCH channels (e.g. I/Q), adding lock acquisition and loss detection, saturating counters and a clear.

Parameters:
- NB_DATA, 8, width of each signed input sample
- OS, 4, oversampling factor; phase counter modulus
- NCH, 2, number of independent channels
- NB_CNT, 64, width of bit/error counters
- WINDOW, 128, bits per trial window and per lock-monitor block
- MAX_ERR, 4, maximum errors tolerated per WINDOW bits

Ports:
- clock, input, 1, system clock
- i_reset, input, 1, asynchronous active-low reset
- i_enable, input, 1, advances phase counter and sampling; when 0 all state holds
- i_phase, input, clog2(OS), sample phase select, shared by all channels
- i_data, input, NCH*NB_DATA, packed signed samples; channel k at [k*NB_DATA +: NB_DATA]
- i_clear, input, 1, synchronous clear of all bit/error counters
- i_ch_sel, input, clog2(NCH) (min 1), channel shown on count outputs
- o_locked, output, NCH, per-channel lock flag
- o_bit_count, output, NB_CNT, bit count of selected channel
- o_err_count, output, NB_CNT, error count of selected channel
- o_ber_zero, output, 1, all channels locked and all error counts 0

Behaviour:
- Reset (i_reset=0, async):
  - phase counter 0; every channel in SYNC;
  - LFSRs, sync/trial/block counters, bit/error counters all 0;
  - o_locked=0, o_ber_zero=0.
- Phase counter pc:
  - increments mod OS each clock with i_enable=1.
  - Sample strobe when i_enable=1 and pc==i_phase.
  - A change of i_phase takes effect at the next clock; it may skip or duplicate one symbol, which is permitted.
- Slicer:
  - on a strobe, rx_bit[k] <= MSB of channel k sample (negative -> 1, matching bit 1 -> -1 mapping) and bit_vld <= 1.
  - The FSM consumes (rx_bit, bit_vld) on the next clock.
  - Counters are visible 2 clocks after the strobe cycle.
- PRBS9 checker, x^9+x^5+1, state s[8:0]:
  - predicted bit p = s[8]^s[4];
  - error e = rx_bit ^ p.
- Per-channel FSM; state advances only on bit_vld:
  - SYNC:
    - s <= {s[7:0], rx_bit}; sync_cnt++.
    - After the 9th bit, clear trial counters and go to TRIAL.
  - TRIAL:
    - s <= {s[7:0], p} (free-running); trial_err += e; trial_bits++.
    - When trial_bits reaches WINDOW: go to LOCKED if trial_err <= MAX_ERR (the WINDOW-th bit included), else go to SYNC.
    - No bit/error counting in TRIAL.
  - LOCKED:
    - s free-runs; bit_count++; err_count += e; blk_err += e; blk_bits++.
    - At WINDOW, blk_bits and blk_err reset to 0.
    - The bit whose error makes blk_err = MAX_ERR+1 is still counted; channel then goes to SYNC with o_locked=0 on that edge.
    - Counters hold while not LOCKED.
- o_locked[k] is 1 exactly when channel k is in LOCKED (registered).
- Counters:
  - unsigned, saturate at 2^NB_CNT-1; error count saturates independently.
  - i_clear zeroes all counters on the next edge; clear beats simultaneous increment; FSM and lock are unaffected.
- Count outputs are a combinational mux of registered counters by i_ch_sel; an i_ch_sel >= NCH selects channel 0.
- o_ber_zero = &o_locked && all err_count == 0 (combinational from registers).
- With i_enable=0 mid-lock, nothing advances and lock is kept.

Decomposition:
- Package ber_pkg holds:
  - FSM state encoding (SYNC=0, TRIAL=1, LOCKED=2);
  - PRBS9 tap constants (9, 5);
  - a next-state/predict function;
  - a clog2 helper.
- Sub-module prbs_checker_ch: one channel's LFSR, FSM, window counters and saturating counters.
  - Inputs: rx_bit, bit_vld, i_clear. Outputs: locked, bit_count, err_count.
  - Instantiated NCH times via generate.
- ber_monitor owns the phase counter, slicers and output mux.

Test Plan:
- Reset: hold i_reset=0 with random i_data/i_enable -> o_locked=00, counts 0, o_ber_zero=0; release -> all still 0 until data arrives.
- Clean lock, defaults:
  - stimulus: PRBS9 seed 0x1AA, BPSK +/-64, each symbol held OS=4 clocks, i_phase=2, both channels;
  - o_locked=11 after the 137th bit (9+128);
  - after 1000 more bits: bit_count=1000, err_count=0, o_ber_zero=1.
- Sparse errors: while locked, flip 1 bit per 200 -> err_count +1 per flip (no error multiplication); lock held; o_ber_zero=0 after the first flip.
- Burst loss:
  - 5 flips within one block -> lock drops on the 5th flip, and that error is counted;
  - counters then hold;
  - clean data -> relock after 137 bits, and counting resumes from the held values.
- Channel independence/no-lock: ch0 clean, ch1 random bits -> o_locked=01; i_ch_sel=1 shows bit_count=0; o_ber_zero=0.
- Saturation/clear:
  - NB_CNT=8 with 300 locked bits -> bit_count=255 and holds;
  - i_clear asserted on a bit_vld cycle -> counts 0 next cycle;
  - o_locked stays 1.
